// File: rtl/noc_router_rr.sv
// N-port router: per-input FIFOs, per-output round-robin crossbar, registered outputs, bad-destination drop.
// One edge from push to head, one more to a valid output; a stalled output holds its flit and FIFOs fill behind it.

module noc_router_rr_fifo #(
   parameter int DW    = 16,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [DW-1:0] pushData,
   input  logic          pop,
   output logic [DW-1:0] headData,
   output logic          empty,
   output logic          full,
   output logic          almostFull
);
   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wrPtr, rdPtr;
   logic [AW:0]   count;
   logic          doPush;

   // Full is judged from occupancy alone, so a pop never frees room for a same-edge write.
   assign doPush     = push && !full;
   assign headData   = mem[rdPtr];
   assign empty      = (count == '0);
   assign full       = (count == (AW+1)'(DEPTH));
   assign almostFull = (count >= (AW+1)'(DEPTH-1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + AW'(1);
         if (pop)    rdPtr <= rdPtr + AW'(1);
         if (doPush && !pop)      count <= count + (AW+1)'(1);
         else if (pop && !doPush) count <= count - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtr] <= pushData;
   end
endmodule

module noc_router_rr #(
   parameter int NPORTS = 3,
   parameter int DW     = 16,
   parameter int DEPTH  = 4,
   parameter int CNTW   = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NPORTS-1:0]    in_valid,
   input  logic [NPORTS*DW-1:0] in_data,
   output logic [NPORTS-1:0]    in_ready,
   output logic [NPORTS-1:0]    in_almost_full,
   output logic [NPORTS-1:0]    out_valid,
   output logic [NPORTS*DW-1:0] out_data,
   input  logic [NPORTS-1:0]    out_ready,
   output logic [CNTW-1:0]      drop_cnt,
   output logic                 drop_err
);
   localparam int DSTW = $clog2(NPORTS);

   logic [DW-1:0]     head [NPORTS];
   logic [NPORTS-1:0] fifoEmpty, fifoFull, fifoPop, badDst;
   logic [NPORTS-1:0] req [NPORTS];
   logic [NPORTS-1:0] grantVld;
   logic [DSTW-1:0]   winner [NPORTS];
   logic [DSTW-1:0]   rrPtr [NPORTS];
   logic [DW-1:0]     outReg [NPORTS];
   logic [CNTW-1:0]   dropCnt;
   logic              dropErr;
   logic [3:0]        dropsNow;
   logic [CNTW+3:0]   dropSum;
   int                idx;

   for (genvar i = 0; i < NPORTS; i++) begin : g_port
      noc_router_rr_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
         .clk        (clk),
         .reset      (reset),
         .push       (in_valid[i]),
         .pushData   (in_data[i*DW +: DW]),
         .pop        (fifoPop[i]),
         .headData   (head[i]),
         .empty      (fifoEmpty[i]),
         .full       (fifoFull[i]),
         .almostFull (in_almost_full[i])
      );
      assign out_data[i*DW +: DW] = outReg[i];
   end

   assign in_ready = ~fifoFull;
   assign drop_cnt = dropCnt;
   assign drop_err = dropErr;

   // req[o][i]: input i's head wants output o; heads beyond the last port are flagged for discard.
   always_comb begin
      badDst = '0;
      for (int o = 0; o < NPORTS; o++) req[o] = '0;
      for (int i = 0; i < NPORTS; i++) begin
         if (!fifoEmpty[i]) begin
            if (32'(head[i][DSTW:1]) >= NPORTS) badDst[i] = 1'b1;
            else req[head[i][DSTW:1]][i] = 1'b1;
         end
      end
   end

   always_comb begin
      grantVld = '0;
      fifoPop  = badDst;
      idx      = 0;
      for (int o = 0; o < NPORTS; o++) begin
         winner[o] = '0;
         if (!out_valid[o] || out_ready[o]) begin
            for (int k = 1; k <= NPORTS; k++) begin
               idx = (int'(rrPtr[o]) + k) % NPORTS;
               if (!grantVld[o] && req[o][idx]) begin
                  grantVld[o] = 1'b1;
                  winner[o]   = DSTW'(idx);
               end
            end
         end
         if (grantVld[o]) fifoPop[winner[o]] = 1'b1;
      end
   end

   always_comb begin
      dropsNow = '0;
      for (int i = 0; i < NPORTS; i++) dropsNow = dropsNow + 4'(badDst[i]);
   end
   assign dropSum = (CNTW+4)'(dropCnt) + (CNTW+4)'(dropsNow);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= '0;
         dropCnt   <= '0;
         dropErr   <= 1'b0;
         for (int o = 0; o < NPORTS; o++) begin
            outReg[o] <= '0;
            rrPtr[o]  <= DSTW'(NPORTS-1);
         end
      end else begin
         for (int o = 0; o < NPORTS; o++) begin
            if (grantVld[o]) begin
               out_valid[o] <= 1'b1;
               outReg[o]    <= head[winner[o]];
               rrPtr[o]     <= winner[o];
            end else if (out_ready[o]) begin
               out_valid[o] <= 1'b0;
            end
         end
         if (dropSum > (CNTW+4)'({CNTW{1'b1}})) dropCnt <= '1;
         else dropCnt <= dropSum[CNTW-1:0];
         if (|badDst) dropErr <= 1'b1;
      end
   end
endmodule

// File: tb/tb_noc_router_rr.sv
// Directed bench for noc_router_rr with a queue-level reference model checked every cycle.
module tb_noc_router_rr;
   localparam int NP = 3, DW = 16, DEPTH = 4, CNTW = 8, TXN = 512;

   logic            clk = 1'b0, reset = 1'b1;
   logic [NP-1:0]   in_valid = '0, out_ready = '1;
   logic [NP*DW-1:0] in_data = '0;
   logic [NP-1:0]   in_ready, in_almost_full, out_valid;
   logic [NP*DW-1:0] out_data;
   logic [CNTW-1:0] drop_cnt;
   logic            drop_err;

   noc_router_rr #(.NPORTS(NP), .DW(DW), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .in_almost_full(in_almost_full), .out_valid(out_valid),
      .out_data(out_data), .out_ready(out_ready), .drop_cnt(drop_cnt), .drop_err(drop_err));

   initial forever #5 clk = ~clk;

   int nVec = 0, nErr = 0;
   bit checkEn = 0, drvEn = 1, beefSeen = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nVec++;
      if (act !== exp) begin
         nErr++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] mk(input int src, input int seq, input int dst);
      return {4'(src), 9'(seq), 2'(dst), 1'b0};
   endfunction

   function automatic int dstOf(input logic [15:0] f);
      return int'(f[2:1]);
   endfunction

   // Reference model: each FIFO is an ordered list; each output remembers its last winner.
   logic [DW-1:0] mbuf [NP][DEPTH];
   int            mn [NP] = '{default: 0};
   bit            mOv [NP] = '{default: 0};
   logic [DW-1:0] mOd [NP] = '{default: '0};
   int            mPtr [NP] = '{default: NP-1};
   int            mCnt = 0;
   bit            mErr = 0;

   initial forever begin : model
      bit acc [NP];
      bit popIt [NP];
      int win, j;
      @(posedge clk or posedge reset);
      if (reset) begin
         for (int i = 0; i < NP; i++) begin
            mn[i] = 0; mOv[i] = 0; mOd[i] = '0; mPtr[i] = NP-1;
         end
         mCnt = 0; mErr = 0;
      end else begin
         for (int i = 0; i < NP; i++) begin
            acc[i] = in_valid[i] && (mn[i] < DEPTH);
            popIt[i] = 0;
            if (mn[i] > 0 && dstOf(mbuf[i][0]) >= NP) begin
               popIt[i] = 1; mErr = 1;
               if (mCnt < (1 << CNTW) - 1) mCnt++;
            end
         end
         for (int o = 0; o < NP; o++) begin
            if (!mOv[o] || out_ready[o]) begin
               win = -1;
               for (int k = 1; k <= NP; k++) begin
                  j = (mPtr[o] + k) % NP;
                  if (win < 0 && mn[j] > 0 && dstOf(mbuf[j][0]) == o) win = j;
               end
               if (win >= 0) begin
                  mOv[o] = 1; mOd[o] = mbuf[win][0]; mPtr[o] = win; popIt[win] = 1;
               end else mOv[o] = 0;
            end
         end
         for (int i = 0; i < NP; i++) begin
            if (popIt[i]) begin
               for (int s = 0; s < DEPTH-1; s++) mbuf[i][s] = mbuf[i][s+1];
               mn[i]--;
            end
            if (acc[i]) begin
               mbuf[i][mn[i]] = in_data[i*DW +: DW];
               mn[i]++;
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (checkEn) begin
         for (int o = 0; o < NP; o++) begin
            chk("cyc_out_valid", 32'(out_valid[o]), 32'(mOv[o]));
            chk("cyc_out_data", 32'(out_data[o*DW +: DW]), 32'(mOd[o]));
            if (out_valid[o] && out_data[o*DW +: DW] == 16'hBEEF) beefSeen = 1;
         end
         for (int i = 0; i < NP; i++) begin
            chk("cyc_in_ready", 32'(in_ready[i]), 32'(mn[i] < DEPTH));
            chk("cyc_almost_full", 32'(in_almost_full[i]), 32'(mn[i] >= DEPTH-1));
         end
         chk("cyc_drop_cnt", 32'(drop_cnt), 32'(mCnt));
         chk("cyc_drop_err", 32'(drop_err), 32'(mErr));
      end
   end

   // Stimulus streams: one list per input, presented in order and held until accepted.
   logic [DW-1:0] txBuf [NP][TXN];
   int txHd [NP] = '{default: 0};
   int txTl [NP] = '{default: 0};
   logic [NP-1:0] rdyPrev = '0;

   initial forever begin
      @(negedge clk);
      if (drvEn && !reset) begin
         for (int i = 0; i < NP; i++) begin
            if (in_valid[i] && rdyPrev[i]) txHd[i]++;
            if (txHd[i] < txTl[i]) begin
               in_valid[i] = 1'b1;
               in_data[i*DW +: DW] = txBuf[i][txHd[i]];
            end else in_valid[i] = 1'b0;
         end
      end
      rdyPrev = in_ready;
   end

   task automatic send(input int i, input logic [15:0] f);
      txBuf[i][txTl[i]] = f;
      txTl[i]++;
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic waitDrain(input int maxCyc);
      int n = 0;
      while (n < maxCyc && (in_valid != '0 || txHd[0] < txTl[0] || txHd[1] < txTl[1] || txHd[2] < txTl[2])) begin
         step(1); n++;
      end
      chk("drain_timeout", 32'(n < maxCyc), 32'd1);
   endtask

   initial begin
      int n;
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      step(3);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'h7);
      chk("rst_almost_full", 32'(in_almost_full), 32'd0);
      chk("rst_drop", {23'd0, drop_err, drop_cnt}, 32'd0);
      reset = 1'b0;
      checkEn = 1;
      step(1);

      // 1: single flit input 0 -> output 1
      send(0, 16'h0003);
      step(2);
      chk("t1_not_yet", 32'(out_valid), 32'd0);
      step(1);
      chk("t1_valid", 32'(out_valid), 32'b010);
      chk("t1_data", 32'(out_data[31:16]), 32'h0003);
      step(1);
      chk("t1_clear", 32'(out_valid), 32'd0);

      // 2: three inputs contend for output 2
      for (int s = 0; s < 4; s++)
         for (int i = 0; i < NP; i++) send(i, mk(i, s, 2));
      n = 0;
      while (!out_valid[2] && n < 20) begin step(1); n++; end
      chk("t2_latency", n, 3);
      for (int j = 0; j < 12; j++) begin
         chk("t2_valid", 32'(out_valid[2]), 32'd1);
         chk("t2_src", 32'(out_data[47:44]), j % 3);
         chk("t2_seq", 32'(out_data[43:35]), j / 3);
         step(1);
      end
      chk("t2_done", 32'(out_valid), 32'd0);

      // 3: backpressure on output 1
      out_ready = 3'b101;
      for (int s = 0; s < 5; s++) send(0, mk(0, s, 1));
      step(10);
      chk("t3_held_valid", 32'(out_valid[1]), 32'd1);
      chk("t3_held_data", 32'(out_data[31:16]), 32'(mk(0, 0, 1)));
      chk("t3_full", 32'(in_ready[0]), 32'd0);
      chk("t3_almost_full", 32'(in_almost_full[0]), 32'd1);

      // 4: write into a full FIFO is ignored
      drvEn = 0;
      in_valid[0] = 1'b1;
      in_data[15:0] = 16'hBEEF;
      step(2);
      in_valid = '0;
      drvEn = 1;
      chk("t4_still_full", 32'(in_ready[0]), 32'd0);
      chk("t4_no_drop", 32'(drop_cnt), 32'd0);

      out_ready = 3'b111;
      for (int j = 1; j < 5; j++) begin
         step(1);
         chk("t3_drain_valid", 32'(out_valid[1]), 32'd1);
         chk("t3_drain_data", 32'(out_data[31:16]), 32'(mk(0, j, 1)));
      end
      step(1);
      chk("t3_drained", 32'(out_valid), 32'd0);

      // 5: invalid destination on input 2
      send(2, 16'h0007);
      step(2);
      chk("t5_cnt_early", 32'(drop_cnt), 32'd0);
      step(1);
      chk("t5_cnt_one", 32'(drop_cnt), 32'd1);
      chk("t5_err", 32'(drop_err), 32'd1);
      chk("t5_no_out", 32'(out_valid), 32'd0);
      for (int j = 0; j < 299; j++) send(2, 16'h0007);
      waitDrain(400);
      step(3);
      chk("t5_saturated", 32'(drop_cnt), 32'd255);
      chk("t5_err_sticky", 32'(drop_err), 32'd1);

      // 6: asynchronous reset with flits in flight
      out_ready = 3'b110;
      send(0, mk(0, 0, 0));
      send(1, mk(1, 0, 0));
      send(1, mk(1, 1, 0));
      step(6);
      chk("t6_pre_valid", 32'(out_valid[0]), 32'd1);
      chk("t6_pre_data", 32'(out_data[15:0]), 32'(mk(0, 0, 0)));
      drvEn = 0;
      #2 reset = 1'b1;
      #1;
      chk("t6_rst_valid", 32'(out_valid), 32'd0);
      chk("t6_rst_ready", 32'(in_ready), 32'h7);
      chk("t6_rst_data", 32'(out_data), 32'd0);
      chk("t6_rst_drop", {23'd0, drop_err, drop_cnt}, 32'd0);
      step(2);
      reset = 1'b0;
      out_ready = 3'b111;
      drvEn = 1;
      send(0, mk(0, 1, 0));
      send(1, mk(1, 2, 0));
      send(2, mk(2, 0, 0));
      step(3);
      for (int j = 0; j < 3; j++) begin
         chk("t6_rr_valid", 32'(out_valid[0]), 32'd1);
         chk("t6_rr_src", 32'(out_data[15:12]), j);
         step(1);
      end
      chk("t4_beef_never", 32'(beefSeen), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end
endmodule

// File: doc/noc_router_rr.md
Name: noc_router_rr

Overview:
Parametrised N-port NoC router and successor to the fixed 3-port router. It provides:
- per-input FIFOs with valid/ready flow control,
- a crossbar with per-output round-robin arbitration,
- registered outputs with backpressure,
- detection of flits addressed to a non-existent port.

It sits between network-interface injectors and neighbouring routers. It replaces the fixed-priority, no-backpressure datapath.

Parameters:
NPORTS, 3, number of ports (input i and output i form port i); range 2..8
DW, 16, flit width in bits; must be >= DSTW+1
DEPTH, 4, per-input FIFO depth in flits; power of two, >= 2
DSTW, $clog2(NPORTS), derived (localparam); width of the destination field
CNTW, 8, width of the drop counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high
in_valid  input  NPORTS  per-input write request
in_data  input  NPORTS*DW  input flits; port i occupies [i*DW +: DW]
in_ready  output  NPORTS  per-input: FIFO not full
in_almost_full  output  NPORTS  per-input: FIFO count >= DEPTH-1
out_valid  output  NPORTS  per-output: registered flit valid
out_data  output  NPORTS*DW  output flits; port i occupies [i*DW +: DW]
out_ready  input  NPORTS  per-output: downstream accepts
drop_cnt  output  CNTW  saturating count of dropped flits
drop_err  output  1  sticky: set on first drop, cleared only by reset

Behaviour:
- Clock and reset: clk is the clock; reset is asynchronous and active-high.
- Reset values:
  - all FIFOs empty; in_ready all 1; in_almost_full all 0;
  - out_valid 0 and out_data 0;
  - drop_cnt 0; drop_err 0;
  - every round-robin pointer set to NPORTS-1, so input 0 has first priority.
- Flit format:
  - bits [DSTW:1] = destination output index;
  - bit 0 and bits above DSTW are payload, carried unmodified.
- Input push:
  - occurs when in_valid[i] && in_ready[i] at a rising edge;
  - in_ready[i] = (count_i != DEPTH), purely from occupancy;
  - no same-cycle pop-credit: a full FIFO refuses the write even if it pops that cycle;
  - a write with in_ready low is ignored.
- FIFO:
  - circular buffer, wrap-around pointers, count 0..DEPTH;
  - no empty bypass: a flit written at edge k is first visible as head after edge k.
- Request: FIFO i, when non-empty, requests output d = head_i[DSTW:1].
- Output load condition: output o may load when !out_valid[o] || out_ready[o].
- Arbitration (combinational, per output o, among requesting inputs):
  - grant the first requester found searching from ptr_o+1, wrapping modulo NPORTS;
  - grant only if the load condition holds;
  - on grant at an edge: pop the winning FIFO, load out_data[o] with its head, set out_valid[o] = 1, set ptr_o = winner.
  - ptr_o is unchanged when nothing is granted.
- Hold and clear:
  - when out_valid[o] && !out_ready[o], out_data[o] is held stable;
  - when out_ready[o] is high and there is no new grant, out_valid[o] clears; out_data keeps its last value.
- Latency and throughput:
  - uncontended: flit accepted at edge k, out_valid asserted after edge k+1;
  - one flit per output per cycle;
  - inputs targeting different outputs are serviced in parallel.
- Invalid destination (d >= NPORTS):
  - the head is popped at the next edge without driving any output;
  - drop_cnt increments, saturating at 2^CNTW-1;
  - drop_err sets.
- Simultaneous events:
  - push and pop on the same FIFO in the same cycle: count unchanged, both take effect;
  - each input pops at most one flit per cycle, since its head requests exactly one output.
- Reset mid-operation: in-flight flits are discarded and all state returns to reset values immediately.

Test Plan:
1. Single flit: in_data[0] = 16'h0003 (dest 1), in_valid[0] pulsed at edge k, out_ready all 1 -> out_valid[1] = 1 after edge k+1 with out_data[1] = 16'h0003; other outputs stay 0.
2. Contention, three inputs to output 2:
   - stimulus: every input (0,1,2) has 4 flits to dest 2, out_ready = 1; out_valid asserts after edge 2 (one edge after the first flits are accepted at edge 1);
   - required: out_data[2] sources cycle in order 0,1,2,0,1,2,... over 12 consecutive cycles;
   - required: all in_ready fall to 0 only when count = 4.
3. Backpressure:
   - stimulus: out_ready[1] = 0 for 10 cycles while input 0 streams to dest 1;
   - required: out_data[1] is stable and out_valid[1] = 1;
   - required: FIFO 0 fills, in_almost_full[0] rises at count 3, in_ready[0] = 0 at count 4;
   - required: after release, all 5 flits (1 register + 4 FIFO) drain in order, one per cycle.
4. Full boundary: FIFO 0 full, out_ready low, in_valid[0] = 1 with data 16'hBEEF -> write dropped silently; 16'hBEEF never appears at any output.
5. Invalid destination: NPORTS = 3, flit 16'h0007 (dest 3) on input 2 -> no out_valid; drop_cnt = 1 and drop_err = 1 two edges later. 300 such flits -> drop_cnt = 255 (saturated).
6. Reset mid-operation: 2 flits in FIFO 1 and out_valid[0] = 1 with out_ready low; assert reset asynchronously between clock edges -> out_valid = 0 and in_ready = 3'b111 immediately; after release, the first grant for any contended output goes to input 0.
